// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_pkg
//  Purpose  : Shared defaults and helpers for the programmable serial
//             sequence detector (seq_det_prog).
//  Contents : W_DEF, CNT_W_DEF, OVL_DEF_DEF  - parameter defaults
//             clamp_len()                    - maps a requested pattern length
//                                              onto the legal range 1..W
//  Revision : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    localparam int W_DEF       = 8;  // maximum pattern length in bits
    localparam int CNT_W_DEF   = 8;  // match-counter width
    localparam int OVL_DEF_DEF = 1;  // reset overlap mode (1 = overlapping)

    // A length of zero, or one longer than the history register, cannot be
    // matched meaningfully, so both fall back to the full width.
    function automatic int unsigned clamp_len(input int unsigned req_len,
                                              input int unsigned max_len);
        if ((req_len == 0) || (req_len > max_len)) begin
            return max_len;
        end
        return req_len;
    endfunction

endpackage : seq_det_pkg
`default_nettype wire

// File: rtl/sat_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : sat_cnt
//  Purpose  : Up-counter that sticks at its all-ones value instead of
//             wrapping.
//  Ports    : clk  - rising-edge clock
//             rst  - synchronous active-high reset (count -> 0)
//             inc  - add one on this edge unless saturated
//             clr  - synchronous clear (count -> 0), lower priority than rst
//             cnt  - current count, WIDTH bits
//  Revision : 1.0 - initial release
// ============================================================================
module sat_cnt #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule : sat_cnt
`default_nettype wire

// File: rtl/seq_det_prog.sv
`default_nettype none
// ============================================================================
//  Module   : seq_det_prog
//  Purpose  : Programmable serial sequence detector. Bits arrive MSB-first
//             on din (qualified by din_vld) and are compared against a
//             runtime-loadable pattern of 1..W bits, in overlapping or
//             non-overlapping mode.
//  Ports    : clk       - rising-edge clock
//             rst       - synchronous active-high reset
//             din       - serial data bit
//             din_vld   - din is accepted only when high
//             pat       - pattern; pat[len-1] is compared with the oldest bit
//             pat_len   - requested pattern length (0 or >W means W)
//             ovl       - overlap mode, latched together with the pattern
//             pat_load  - one-cycle strobe latching pat / pat_len / ovl
//             dout      - registered one-cycle match pulse
//             match_cnt - saturating match count
//             armed     - history holds at least len valid bits
//  Revision : 1.0 - initial release
// ============================================================================
module seq_det_prog
    import seq_det_pkg::*;
#(
    parameter int W       = W_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter int OVL_DEF = OVL_DEF_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din,
    input  logic                   din_vld,
    input  logic [W-1:0]           pat,
    input  logic [$clog2(W+1)-1:0] pat_len,
    input  logic                   ovl,
    input  logic                   pat_load,
    output logic                   dout,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   armed
);

    localparam int LW = $clog2(W+1);

    localparam logic [LW-1:0] c_len_rst = LW'(W);
    localparam logic          c_ovl_rst = (OVL_DEF != 0);

    logic [W-1:0]  r_hist;
    logic [LW-1:0] r_fill;
    logic          r_dout;
    logic [W-1:0]  r_pat;
    logic [LW-1:0] r_len;
    logic          r_ovl;

    logic          w_accept;
    logic [W-1:0]  w_hist_next;
    logic [W-1:0]  w_mask;
    logic [LW-1:0] w_fill_inc;
    logic          w_match;
    logic [LW-1:0] w_len_load;

    // pat_load has priority over an incoming bit, which is then discarded.
    assign w_accept    = din_vld & ~pat_load;
    assign w_hist_next = {r_hist[W-2:0], din};
    assign w_fill_inc  = (r_fill == r_len) ? r_fill : (r_fill + 1'b1);
    assign w_len_load  = LW'(clamp_len(32'(pat_len), W));

    // Only the low len bits of history and pattern take part in the compare.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < W; i++) begin
            w_mask[i] = (i < int'(r_len));
        end
    end

    // Evaluated on the post-shift history and post-increment fill so that
    // the pulse appears on the same edge that accepts the final bit.
    assign w_match = w_accept
                   && ((w_hist_next & w_mask) == (r_pat & w_mask))
                   && (w_fill_inc == r_len);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_dout <= 1'b0;
            r_pat  <= '0;
            r_len  <= c_len_rst;
            r_ovl  <= c_ovl_rst;
        end else if (pat_load) begin
            r_pat  <= pat;
            r_len  <= w_len_load;
            r_ovl  <= ovl;
            r_hist <= '0;
            r_fill <= '0;
            r_dout <= 1'b0;
        end else if (din_vld) begin
            r_hist <= w_hist_next;
            r_dout <= w_match;
            // Non-overlapping mode restarts the fill so the next match needs
            // a full fresh pattern; overlapping mode keeps the window full.
            r_fill <= (w_match && !r_ovl) ? '0 : w_fill_inc;
        end else begin
            r_dout <= 1'b0;
        end
    end

    sat_cnt #(
        .WIDTH (CNT_W)
    ) u_match_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_match),
        .clr (1'b0),
        .cnt (match_cnt)
    );

    assign dout  = r_dout;
    assign armed = (r_fill == r_len);

endmodule : seq_det_prog
`default_nettype wire

// File: tb/tb_seq_det_prog.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_det_prog
//  Purpose  : Self-checking bench for seq_det_prog (W=8, CNT_W=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_det_prog;

    logic       clk;
    logic       rst;
    logic       din;
    logic       din_vld;
    logic [7:0] pat;
    logic [3:0] pat_len;
    logic       ovl;
    logic       pat_load;
    logic       dout;
    logic [1:0] match_cnt;
    logic       armed;

    int n_cmp;
    int n_err;

    seq_det_prog #(
        .W       (8),
        .CNT_W   (2),
        .OVL_DEF (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .pat       (pat),
        .pat_len   (pat_len),
        .ovl       (ovl),
        .pat_load  (pat_load),
        .dout      (dout),
        .match_cnt (match_cnt),
        .armed     (armed)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       r;
        logic       ld;
        logic [7:0] p;
        logic [3:0] pl;
        logic       o;
        logic       d;
        logic       v;
        logic       e_dout;
        logic [1:0] e_cnt;
        logic       e_armed;
    } vec_t;

    function automatic vec_t mk(input logic r, ld, input logic [7:0] p,
                                input logic [3:0] pl, input logic o, d, v,
                                input logic e_dout, input logic [1:0] e_cnt,
                                input logic e_armed);
        vec_t t;
        t.r = r; t.ld = ld; t.p = p; t.pl = pl; t.o = o; t.d = d; t.v = v;
        t.e_dout = e_dout; t.e_cnt = e_cnt; t.e_armed = e_armed;
        return t;
    endfunction

    // Apply one edge's worth of inputs and leave time for outputs to settle.
    task automatic tick(input logic r, ld, input logic [7:0] p,
                        input logic [3:0] pl, input logic o, d, v);
        @(negedge clk);
        rst = r; pat_load = ld; pat = p; pat_len = pl; ovl = o;
        din = d; din_vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic e_dout,
                       input logic [1:0] e_cnt, input logic e_armed);
        n_cmp++;
        if (dout !== e_dout) begin
            n_err++;
            $display("FAIL %s dout: got %b want %b", name, dout, e_dout);
        end
        n_cmp++;
        if (match_cnt !== e_cnt) begin
            n_err++;
            $display("FAIL %s match_cnt: got %0d want %0d", name, match_cnt, e_cnt);
        end
        n_cmp++;
        if (armed !== e_armed) begin
            n_err++;
            $display("FAIL %s armed: got %b want %b", name, armed, e_armed);
        end
    endtask

    // Shorthand for a data-only edge with the last loaded pattern untouched.
    task automatic bit_in(input logic d, input logic v);
        tick(1'b0, 1'b0, 8'h00, 4'd0, 1'b0, d, v);
    endtask

    vec_t tv[28];
    logic [7:0] p8;

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1; pat_load = 1'b0; pat = '0; pat_len = '0; ovl = 1'b0;
        din = 1'b0; din_vld = 1'b0;

        // Overlap: 1,0,1,1,0,1,1 against 1011 -> pulses on bits 4 and 7
        tv[0]  = mk(1,0,8'h00,4'd0,0,0,0, 0,2'd0,0);
        tv[1]  = mk(0,1,8'h0B,4'd4,1,0,0, 0,2'd0,0);
        tv[2]  = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd0,0);
        tv[3]  = mk(0,0,8'h00,4'd0,0,0,1, 0,2'd0,0);
        tv[4]  = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd0,0);
        tv[5]  = mk(0,0,8'h00,4'd0,0,1,1, 1,2'd1,1);
        tv[6]  = mk(0,0,8'h00,4'd0,0,0,1, 0,2'd1,1);
        tv[7]  = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd1,1);
        tv[8]  = mk(0,0,8'h00,4'd0,0,1,1, 1,2'd2,1);
        // Non-overlap: same stream -> pulse on bit 4 only, bit 7 too early
        tv[9]  = mk(1,0,8'h00,4'd0,0,0,0, 0,2'd0,0);
        tv[10] = mk(0,1,8'h0B,4'd4,0,0,0, 0,2'd0,0);
        tv[11] = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd0,0);
        tv[12] = mk(0,0,8'h00,4'd0,0,0,1, 0,2'd0,0);
        tv[13] = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd0,0);
        tv[14] = mk(0,0,8'h00,4'd0,0,1,1, 1,2'd1,0);
        tv[15] = mk(0,0,8'h00,4'd0,0,0,1, 0,2'd1,0);
        tv[16] = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd1,0);
        tv[17] = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd1,0);
        // Reload keeps match_cnt; gapped 1011 with idle cycles between bits
        tv[18] = mk(0,1,8'h0B,4'd4,1,0,0, 0,2'd1,0);
        tv[19] = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd1,0);
        tv[20] = mk(0,0,8'h00,4'd0,0,1,0, 0,2'd1,0);
        tv[21] = mk(0,0,8'h00,4'd0,0,0,1, 0,2'd1,0);
        tv[22] = mk(0,0,8'h00,4'd0,0,0,0, 0,2'd1,0);
        tv[23] = mk(0,0,8'h00,4'd0,0,1,1, 0,2'd1,0);
        tv[24] = mk(0,0,8'h00,4'd0,0,1,0, 0,2'd1,0);
        tv[25] = mk(0,0,8'h00,4'd0,0,1,1, 1,2'd2,1);
        tv[26] = mk(0,0,8'h00,4'd0,0,1,0, 0,2'd2,1);
        tv[27] = mk(0,0,8'h00,4'd0,0,0,0, 0,2'd2,1);

        for (int i = 0; i < 28; i++) begin
            tick(tv[i].r, tv[i].ld, tv[i].p, tv[i].pl, tv[i].o, tv[i].d, tv[i].v);
            chk($sformatf("vec%0d", i), tv[i].e_dout, tv[i].e_cnt, tv[i].e_armed);
        end

        // Load collides with the 3rd bit of 1011: bit dropped, history cleared
        tick(1, 0, 8'h00, 4'd0, 0, 0, 0);
        tick(0, 1, 8'h0B, 4'd4, 1, 0, 0);
        bit_in(1, 1);
        bit_in(0, 1);
        tick(0, 1, 8'h0B, 4'd4, 1, 1, 1);
        chk("coll_load", 0, 2'd0, 0);
        bit_in(1, 1);
        chk("coll_f1", 0, 2'd0, 0);
        bit_in(0, 1);
        chk("coll_f2", 0, 2'd0, 0);
        bit_in(1, 1);
        chk("coll_f3", 0, 2'd0, 0);
        bit_in(1, 1);
        chk("coll_f4", 1, 2'd1, 1);

        // Five overlapping matches of 1011 with a 2-bit counter -> sticks at 3
        tick(1, 0, 8'h00, 4'd0, 0, 0, 0);
        tick(0, 1, 8'h0B, 4'd4, 1, 0, 0);
        bit_in(1, 1);
        chk("sat_b1", 0, 2'd0, 0);
        for (int m = 1; m <= 5; m++) begin
            bit_in(0, 1);
            bit_in(1, 1);
            chk($sformatf("sat_m%0d_pre", m), 0, (m == 1) ? 2'd0 : ((m > 4) ? 2'd3 : 2'(m - 1)), (m != 1));
            bit_in(1, 1);
            chk($sformatf("sat_m%0d", m), 1, (m >= 3) ? 2'd3 : 2'(m), 1);
        end

        // Length clamp: pat_len 0 and pat_len 9 both mean the full 8 bits
        for (int k = 0; k < 2; k++) begin
            tick(0, 1, 8'b1011_0011, (k == 0) ? 4'd0 : 4'd9, 1, 0, 0);
            chk($sformatf("clamp%0d_load", k), 0, 2'd3, 0);
            p8 = 8'b1011_0011;
            for (int b = 7; b >= 0; b--) begin
                bit_in(p8[b], 1);
                chk($sformatf("clamp%0d_b%0d", k, 7 - b), (b == 0), 2'd3, (b == 0));
            end
        end

        // Reset mid-pattern discards history and restores pat=0, len=8
        tick(1, 0, 8'h00, 4'd0, 0, 0, 0);
        tick(0, 1, 8'h0B, 4'd4, 1, 0, 0);
        bit_in(1, 1);
        bit_in(0, 1);
        bit_in(1, 1);
        tick(1, 0, 8'h00, 4'd0, 0, 1, 1);
        chk("rst_state", 0, 2'd0, 0);
        bit_in(1, 1);
        chk("rst_next1", 0, 2'd0, 0);
        for (int z = 1; z <= 8; z++) begin
            bit_in(0, 1);
            chk($sformatf("rst_zero%0d", z), (z == 8), (z == 8) ? 2'd1 : 2'd0, (z >= 7));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_seq_det_prog
`default_nettype wire
